// File: rtl/fft_bitrev_buffer.sv
// Ping-pong reorder buffer: natural-order complex samples in, bit-reversed frames out.
// Optional start-of-frame framing and sticky frame error when BITREV_SOF_EN is defined.
module fft_bitrev_buffer #(
  parameter int N        = 16,
  parameter int LOG2_PTS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        in_re,
  input  logic [N-1:0]        in_im,
`ifdef BITREV_SOF_EN
  input  logic                in_sof,
  output logic                frame_err,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_re,
  output logic [N-1:0]        out_im,
  output logic [LOG2_PTS-1:0] out_index,
  output logic                out_last
);

  localparam int POINTS = 1 << LOG2_PTS;
  localparam logic [LOG2_PTS-1:0] LAST_IDX = LOG2_PTS'(POINTS - 1);

  logic [2*N-1:0]      r_mem [2*POINTS];
  logic                r_wr_bank;
  logic                r_rd_bank;
  logic [LOG2_PTS-1:0] r_wr_cnt;
  logic [LOG2_PTS-1:0] r_rd_cnt;
  logic [1:0]          r_bank_full;
  logic                r_out_valid;
  logic [N-1:0]        r_out_re;
  logic [N-1:0]        r_out_im;
  logic [LOG2_PTS-1:0] r_out_index;
  logic                r_out_last;

  logic                w_sof;
  logic                w_wr_fire;
  logic                w_wr_done;
  logic [LOG2_PTS-1:0] w_wr_addr;
  logic                w_load;
  logic                w_rd_done;
  logic [LOG2_PTS-1:0] w_rd_rev;
  logic [2*N-1:0]      w_rd_word;

`ifdef BITREV_SOF_EN
  logic r_frame_err;
  assign w_sof     = in_sof;
  assign frame_err = r_frame_err;
`else
  assign w_sof = 1'b0;
`endif

  assign in_ready  = !r_bank_full[r_wr_bank];
  assign w_wr_fire = in_valid && in_ready;
  // A start-of-frame sample always lands at index 0 and never completes a frame.
  assign w_wr_addr = w_sof ? '0 : r_wr_cnt;
  assign w_wr_done = w_wr_fire && !w_sof && (r_wr_cnt == LAST_IDX);

  assign w_load    = r_bank_full[r_rd_bank] && (!r_out_valid || out_ready);
  assign w_rd_done = w_load && (r_rd_cnt == LAST_IDX);
  assign w_rd_word = r_mem[{r_rd_bank, w_rd_rev}];

  genvar gi;
  generate
    for (gi = 0; gi < LOG2_PTS; gi++) begin : g_rev
      assign w_rd_rev[gi] = r_rd_cnt[LOG2_PTS-1-gi];
    end
    // Writer only completes a non-full bank and reader only drains a full one,
    // so set and clear can never target the same flag in one cycle.
    for (gi = 0; gi < 2; gi++) begin : g_full
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_bank_full[gi] <= 1'b0;
        end else if (w_wr_done && (r_wr_bank == 1'(gi))) begin
          r_bank_full[gi] <= 1'b1;
        end else if (w_rd_done && (r_rd_bank == 1'(gi))) begin
          r_bank_full[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[{r_wr_bank, w_wr_addr}] <= {in_re, in_im};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
    end else if (w_wr_fire) begin
      if (w_sof) begin
        r_wr_cnt <= LOG2_PTS'(1);
      end else if (r_wr_cnt == LAST_IDX) begin
        r_wr_cnt  <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
    end
  end

`ifdef BITREV_SOF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_err <= 1'b0;
    end else if (w_wr_fire && in_sof && (r_wr_cnt != '0)) begin
      r_frame_err <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_bank   <= 1'b0;
      r_rd_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_re    <= w_rd_word[2*N-1:N];
      r_out_im    <= w_rd_word[N-1:0];
      r_out_index <= w_rd_rev;
      r_out_last  <= (r_rd_cnt == LAST_IDX);
      if (r_rd_cnt == LAST_IDX) begin
        r_rd_cnt  <= '0;
        r_rd_bank <= ~r_rd_bank;
      end else begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Bench for fft_bitrev_buffer: frame-level queue model of the bit-reversed reorder,
// checked on every output handshake and every stalled cycle.
module tb_fft_bitrev_buffer;
  localparam int N   = 16;
  localparam int LP  = 5;
  localparam int PTS = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_re = '0;
  logic [N-1:0]  in_im = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  out_re;
  logic [N-1:0]  out_im;
  logic [LP-1:0] out_index;
  logic          out_last;
`ifdef BITREV_SOF_EN
  logic          in_sof = 1'b0;
  logic          frame_err;
  bit            sof_flag = 1'b0;
`endif

  fft_bitrev_buffer #(.N(N), .LOG2_PTS(LP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
`ifdef BITREV_SOF_EN
    .in_sof(in_sof), .frame_err(frame_err),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  re;
    logic [N-1:0]  im;
    logic [LP-1:0] idx;
    logic          last;
  } exp_t;

  exp_t            expq[$];
  logic [2*N-1:0]  cur[$];
  logic [N-1:0]    log_re[$];
  logic [LP-1:0]   log_idx[$];
  int              n_tests = 0;
  int              n_fail = 0;
  int              acc_total = 0;
  int              cyc = 0;
  bit              m_err = 1'b0;
  bit              prev_stall = 1'b0;
  logic [38:0]     prev_word;
  bit              rnd_on;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  function automatic int bitrev(input int i);
    int r = 0;
    for (int b = 0; b < LP; b++)
      if (((i >> b) & 1) != 0) r |= 1 << (LP - 1 - b);
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Reference model: a frame is the next 32 accepted samples; it leaves in bit-reversed order.
  always @(negedge clk) begin
    exp_t           e;
    logic [2*N-1:0] w;
    if (!rst) begin
      cur.delete(); expq.delete(); log_re.delete(); log_idx.delete();
      prev_stall = 1'b0; m_err = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {25'd0, out_valid, out_re, out_im, out_index, out_last}, {25'd0, prev_word});
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = expq.pop_front();
          check("out_re", out_re, e.re);
          check("out_im", out_im, e.im);
          check("out_index", out_index, e.idx);
          check("out_last", out_last, e.last);
        end
        log_re.push_back(out_re);
        log_idx.push_back(out_index);
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_valid, out_re, out_im, out_index, out_last};
      if (in_valid && in_ready) begin
        acc_total++;
`ifdef BITREV_SOF_EN
        if (in_sof) begin
          if (cur.size() != 0) m_err = 1'b1;
          cur.delete();
        end
`endif
        cur.push_back({in_re, in_im});
        if (cur.size() == PTS) begin
          for (int i = 0; i < PTS; i++) begin
            w      = cur[bitrev(i)];
            e.re   = w[2*N-1:N];
            e.im   = w[N-1:0];
            e.idx  = LP'(bitrev(i));
            e.last = (i == PTS - 1);
            expq.push_back(e);
          end
          cur.delete();
        end
      end
    end
  end

  task automatic send(input logic [N-1:0] re, input logic [N-1:0] im);
    int t = 0;
    in_valid = 1'b1; in_re = re; in_im = im;
`ifdef BITREV_SOF_EN
    in_sof = sof_flag;
`endif
    @(negedge clk);
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef BITREV_SOF_EN
    in_sof = 1'b0;
`endif
  endtask

  task automatic wait_drain(input int lim);
    int t = 0;
    while (expq.size() != 0 && t < lim) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", expq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0; in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, gaps, t, bad;
    // Reset state
    @(posedge clk); #1;
    do_reset(5);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef BITREV_SOF_EN
    check("rst_frame_err", frame_err, 0);
`endif

    // One ramp frame, latency and literal order
    @(posedge clk); #1;
    for (int k = 0; k < PTS; k++) send(N'(k), N'(-k));
    check("lat_not_yet", out_valid, 0);
    @(posedge clk); #1;
    check("lat_first_valid", out_valid, 1);
    check("lat_first_re", out_re, 0);
    wait_drain(100);
    check("f1_count", log_re.size(), PTS);
    check("f1_re0", log_re[0], 0);
    check("f1_re1", log_re[1], 16);
    check("f1_re2", log_re[2], 8);
    check("f1_re3", log_re[3], 24);
    check("f1_re31", log_re[31], 31);
    bad = 0;
    for (int i = 0; i < log_re.size(); i++) if (log_idx[i] != LP'(log_re[i])) bad++;
    check("f1_index_eq_re", bad, 0);

    // Three back-to-back random frames: full throughput in and out
    log_re.delete(); log_idx.delete();
    c0 = cyc;
    fork
      begin
        for (int k = 0; k < 3 * PTS; k++) send(N'($urandom), N'($urandom));
        check("bb_in_cycles", cyc - c0, 3 * PTS);
      end
      begin
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 200) begin @(negedge clk); t++; end
        gaps = 0;
        for (int i = 0; i < 3 * PTS; i++) begin
          if (!out_valid) gaps++;
          @(negedge clk);
        end
        check("bb_out_gaps", gaps, 0);
      end
    join
    wait_drain(200);
    check("bb_count", log_re.size(), 3 * PTS);

    // Downstream stalled: both banks fill, then drain
    log_re.delete(); log_idx.delete();
    out_ready = 1'b0;
    acc_total = 0;
    fork
      for (int k = 0; k < 70; k++) send(N'(k), N'($urandom));
      begin
        t = 0;
        while (acc_total < 2 * PTS && t < 2000) begin @(negedge clk); t++; end
        repeat (3) @(posedge clk);
        #1;
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("full_out_re", out_re, 0);
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain(300);
    check("full_in_ready_back", in_ready, 1);
    check("full_count", log_re.size(), 2 * PTS);

    // Reset mid-frame discards the partial frame
    for (int k = 0; k < 10; k++) send(N'(200 + k), N'(k));
    do_reset(2);
    check("mid_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    for (int k = 0; k < PTS; k++) send(N'(100 + k), N'($urandom));
    wait_drain(100);
    check("mid_rst_count", log_re.size(), PTS);
    check("mid_rst_re0", log_re[0], 100);
    check("mid_rst_re1", log_re[1], 116);
    check("mid_rst_re2", log_re[2], 108);

`ifdef BITREV_SOF_EN
    // Start-of-frame inside a partial frame
    log_re.delete(); log_idx.delete();
    check("sof_err_before", frame_err, 0);
    for (int k = 0; k < 7; k++) send(N'(300 + k), N'(k));
    sof_flag = 1'b1;
    send(N'(500), N'(1));
    sof_flag = 1'b0;
    for (int k = 1; k < PTS; k++) send(N'(500 + k), N'(k));
    wait_drain(100);
    check("sof_err_set", frame_err, 1);
    check("sof_err_model", frame_err, m_err);
    check("sof_count", log_re.size(), PTS);
    check("sof_re1", log_re[1], 516);
`endif

    // Random throttling on both sides
    log_re.delete(); log_idx.delete();
    rnd_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 4 * PTS; k++) begin
          if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
          send(N'($urandom), N'($urandom));
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    wait_drain(500);
    check("rnd_count", log_re.size(), 4 * PTS);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
